// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: fetch-stage control bundle between hazard/branch/debug logic and the PC unit
interface pc_ctrl_if #(
    parameter int PC_W       = 32,
    parameter int HIST_DEPTH = 8
);
    localparam int IW = $clog2(HIST_DEPTH);
    logic            db_ena;
    logic            stall;
    logic            jmp;
    logic [PC_W-1:0] jmp_target;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic            halt_in;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus;
    logic            draining;
    logic            halted;
    logic [IW-1:0]   hist_rd_idx;
    logic [PC_W-1:0] hist_pc;
    logic [IW:0]     hist_count;
    modport master (
        output db_ena, stall, jmp, jmp_target, br_taken, br_target, halt_in, hist_rd_idx,
        input  pc, pc_plus, draining, halted, hist_pc, hist_count
    );
    modport slave (
        input  db_ena, stall, jmp, jmp_target, br_taken, br_target, halt_in, hist_rd_idx,
        output pc, pc_plus, draining, halted, hist_pc, hist_count
    );
endinterface

// File: rtl/pc_control_unit.sv
// pc_control_unit: next-PC select with stall/debug-enable, halt drain FSM; PC_HIST_EN adds a PC history buffer
module pc_control_unit #(
    parameter int          PC_W         = 32,
    parameter int unsigned RESET_VEC    = 0,
    parameter int unsigned STEP         = 4,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int          HIST_DEPTH   = 8
) (
    input logic       clk,
    input logic       reset,
    pc_ctrl_if.slave  bus
);
    localparam int IW = $clog2(HIST_DEPTH);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    state_t          state_q;
    logic [7:0]      cnt_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            draining_q;
    logic            halted_q;
    logic            upd;
    assign upd         = bus.db_ena & ~bus.stall & (state_q == RUN);
    assign bus.pc      = pc_q;
    assign bus.pc_plus = pc_q + PC_W'(STEP);
    assign pc_d        = bus.jmp ? bus.jmp_target : bus.br_taken ? bus.br_target : bus.pc_plus;
    assign bus.draining = draining_q;
    assign bus.halted   = halted_q;
    // PC register and RUN/DRAIN/HALTED sequencing; draining/halted are registered state decodes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= PC_W'(RESET_VEC);
            state_q    <= RUN;
            cnt_q      <= '0;
            draining_q <= 1'b0;
            halted_q   <= 1'b0;
        end else if (bus.db_ena) begin
            case (state_q)
                RUN: if (upd) begin
                    pc_q <= pc_d;
                    if (bus.halt_in) begin
                        state_q    <= DRAIN;
                        cnt_q      <= 8'(DRAIN_CYCLES - 1);
                        draining_q <= 1'b1;
                    end
                end
                DRAIN: if (cnt_q == 8'd0) begin
                    state_q    <= HALTED;
                    draining_q <= 1'b0;
                    halted_q   <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 8'd1;
                end
                HALTED: state_q <= HALTED;
                default: begin
                    state_q    <= RUN;
                    draining_q <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end
`ifdef PC_HIST_EN
    logic [PC_W-1:0] hist_q [HIST_DEPTH];
    logic [IW-1:0]   wr_ptr_q;
    logic [IW:0]     hist_count_q;
    logic [IW-1:0]   rd_ptr;
    assign rd_ptr         = wr_ptr_q - IW'(1) - bus.hist_rd_idx;
    assign bus.hist_count = hist_count_q;
    assign bus.hist_pc    = ({1'b0, bus.hist_rd_idx} >= hist_count_q) ? '0 : hist_q[rd_ptr];
    // Write pointer and saturating fill count; entries beyond the count read as zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            hist_count_q <= '0;
        end else if (upd) begin
            wr_ptr_q     <= wr_ptr_q + IW'(1);
            hist_count_q <= (hist_count_q == (IW+1)'(HIST_DEPTH)) ? hist_count_q : hist_count_q + 1'b1;
        end
    end
    // Capture the PC being replaced on every update
    always_ff @(posedge clk) begin
        if (upd) hist_q[wr_ptr_q] <= pc_q;
    end
`else
    logic unused_hist_idx;
    assign unused_hist_idx = ^bus.hist_rd_idx;
    assign bus.hist_pc     = '0;
    assign bus.hist_count  = '0;
`endif
endmodule
